// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl: LFSR-driven built-in self-test controller for bench_comb.
// An LFSR produces IN_W-bit patterns that are applied to the combinational
// block under test. Its responses are folded into an OUT_W-bit MISR, and the
// final MISR contents are compared against a golden signature.
module bench_bist_ctrl #(
  parameter int IN_W  = 60,
  parameter int OUT_W = 26,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [OUT_W-1:0] golden_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [OUT_W-1:0] signature
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEED    = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IN_W-1:0]  lfsr;
  logic [OUT_W-1:0] misr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_reg;

  logic [CNT_W-1:0] cnt_inc;
  logic [IN_W-1:0]  lfsr_step;
  logic [OUT_W-1:0] misr_step;
  logic [IN_W-1:0]  seed_val;
  logic             launch;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign seed_val  = (seed == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;
  assign lfsr_step = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2]};
  assign misr_step = {misr[OUT_W-2:0],
                      misr[OUT_W-1] ^ misr[5] ^ misr[1] ^ misr[0]} ^ dut_out;
  // The counter only ever reaches N, so this increment cannot wrap.
  assign cnt_inc   = cnt + CNT_W'(1);
  // When start and abort arrive together in IDLE, abort wins.
  assign launch    = (state == S_IDLE) && start && !abort;

  assign busy      = (state != S_IDLE);
  assign signature = misr;

  // Next-state logic: the run sequence, with abort overriding it from any active state.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:    if (launch) state_nxt = S_SEED;
      S_SEED:    state_nxt = (n_reg == '0) ? S_COMPARE : S_APPLY;
      S_APPLY:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (cnt_inc == n_reg) ? S_COMPARE : S_APPLY;
      S_COMPARE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // State, pattern generation, response compaction and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
      dut_in <= '0;
      misr   <= '0;
      lfsr   <= {{(IN_W-1){1'b0}}, 1'b1};
      cnt    <= '0;
      n_reg  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      // done is registered, so it pulses in the cycle after DONE; an abort in DONE suppresses it.
      done  <= (state == S_DONE) && !abort;
      if (state == S_IDLE) begin
        if (launch) begin
          n_reg <= num_patterns;
          pass  <= 1'b0;
          fail  <= 1'b0;
        end
      end else if (abort) begin
        // Abandon the run. LFSR, MISR and dut_in keep their current values.
        pass <= 1'b0;
        fail <= 1'b0;
      end else begin
        case (state)
          S_SEED: begin
            lfsr <= seed_val;
            misr <= '0;
            cnt  <= '0;
            // The first pattern is presented on dut_in at the same edge that enters APPLY.
            if (n_reg != '0) dut_in <= seed_val;
          end
          S_CAPTURE: begin
            misr <= misr_step;
            lfsr <= lfsr_step;
            cnt  <= cnt_inc;
            if (cnt_inc != n_reg) dut_in <= lfsr_step;
          end
          S_COMPARE: begin
            pass <= (misr == golden_sig);
            fail <= (misr != golden_sig);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// Self-checking bench for bench_bist_ctrl. A behavioural model computes the
// expected pattern sequence and the expected MISR signature directly from the
// LFSR and MISR rules. dut_out comes from a reference bench_comb or from a
// constant.
module tb_bench_bist_ctrl;

  localparam int IN_W  = 60;
  localparam int OUT_W = 26;
  localparam int CNT_W = 16;
  localparam logic [OUT_W-1:0] TAPS = 26'h2000023;  // bits 25, 5, 1, 0

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  seed;
  logic [CNT_W-1:0] num_patterns;
  logic [OUT_W-1:0] golden_sig;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [OUT_W-1:0] signature;

  logic             out_mode;
  logic [OUT_W-1:0] out_const;

  int checks = 0;
  int errors = 0;

  bench_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .num_patterns (num_patterns),
    .golden_sig   (golden_sig),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .signature    (signature)
  );

  always #5 clk = ~clk;

  // Reference bench_comb.
  function automatic logic [OUT_W-1:0] comb_ref(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] y;
    y    = ~x[OUT_W-1:0];
    y[0] = x[0] & x[1];
    y[1] = x[0] | x[1];
    return y;
  endfunction

  always_comb dut_out = out_mode ? comb_ref(dut_in) : out_const;

  // Pattern number k of a run, counted from 0.
  function automatic logic [IN_W-1:0] model_pat(input logic [IN_W-1:0] sd, input int k);
    logic [IN_W-1:0] r;
    r = (sd == 0) ? IN_W'(1) : sd;
    for (int i = 0; i < k; i++)
      r = (r << 1) | IN_W'(r[IN_W-1] ^ r[IN_W-2]);
    return r;
  endfunction

  // Signature after k responses have been captured.
  function automatic logic [OUT_W-1:0] model_sig(input logic [IN_W-1:0] sd, input int k,
                                                 input logic mode, input logic [OUT_W-1:0] cval);
    logic [OUT_W-1:0] m;
    logic [OUT_W-1:0] resp;
    m = '0;
    for (int i = 0; i < k; i++) begin
      resp = mode ? comb_ref(model_pat(sd, i)) : cval;
      m    = ((m << 1) | OUT_W'(^(m & TAPS))) ^ resp;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(posedge clk);
    #1;
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Launch one run, then check the pattern stream, the done latency and the result.
  task automatic run_test(input string tag, input logic [IN_W-1:0] sd, input int n,
                          input logic mode, input logic [OUT_W-1:0] cval,
                          input logic [OUT_W-1:0] gold);
    logic [OUT_W-1:0] exp_sig;
    int lat;
    int got_lat;
    exp_sig = model_sig(sd, n, mode, cval);
    lat     = (n == 0) ? 3 : 2 * n + 3;
    got_lat = -1;
    wait_idle();
    @(negedge clk);
    out_mode = mode; out_const = cval; seed = sd;
    num_patterns = CNT_W'(n); golden_sig = gold; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int c = 1; c <= lat + 5; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 1 && c < 2 * n)
        check({tag, "_pat"}, dut_in, model_pat(sd, (c - 1) / 2));
      if (done) begin
        got_lat = c;
        break;
      end
    end
    check({tag, "_lat"}, got_lat, lat);
    check({tag, "_sig"}, signature, exp_sig);
    check({tag, "_pass"}, pass, gold == exp_sig);
    check({tag, "_fail"}, fail, gold != exp_sig);
    check({tag, "_idle"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]      r64;
    logic [IN_W-1:0]  sd;
    logic [OUT_W-1:0] cv;
    logic [OUT_W-1:0] es;
    logic             md;
    int               n;
    int               lat;

    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_patterns = '0;
    golden_sig = '0; out_mode = 1'b0; out_const = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_sig", signature, 0);
    @(negedge clk) rst = 1'b0;

    // Directed runs
    run_test("single", 60'h1, 1, 1'b0, 26'h1, 26'h1);
    check("single_lit_sig", signature, 26'h1);
    run_test("two", 60'h1, 2, 1'b0, 26'h1, 26'h3);
    check("two_lit_sig", signature, 26'h2);
    run_test("zero", 60'h5, 0, 1'b0, 26'h3ff, 26'h0);

    // Abort in the 4th APPLY
    sd = 60'hABCDE12345;
    wait_idle();
    @(negedge clk);
    out_mode = 1'b1; seed = sd; num_patterns = 16'd10; golden_sig = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
    end
    check("abort_pat3", dut_in, model_pat(sd, 3));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_fail", fail, 0);
    check("abort_sig_frozen", signature, model_sig(sd, 3, 1'b1, '0));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    run_test("after_abort", 60'h77, 1, 1'b1, '0, model_sig(60'h77, 1, 1'b1, '0));

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("start_abort_idle", busy, 0);
    start = 1'b0; abort = 1'b0;

    // Reset during CAPTURE, then restart from scratch
    sd = 60'hFEED_F00D_1234;
    wait_idle();
    @(negedge clk);
    out_mode = 1'b1; seed = sd; num_patterns = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_pass", pass, 0);
    check("mrst_fail", fail, 0);
    check("mrst_dut_in", dut_in, 0);
    check("mrst_sig", signature, 0);
    run_test("post_rst", sd, 5, 1'b1, '0, model_sig(sd, 5, 1'b1, '0));

    // start held high: ignored while busy, relaunches on the first IDLE cycle
    wait_idle();
    @(negedge clk);
    out_mode = 1'b0; out_const = 26'h1; seed = 60'h1; num_patterns = 16'd2;
    golden_sig = 26'h2; start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("held_lat", lat, 7);
    check("held_pass", pass, 1);
    @(posedge clk); #1;
    check("held_relaunch", busy, 1);
    abort = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("held_abort_idle", busy, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      r64 = {$urandom, $urandom};
      sd  = (r == 0) ? '0 : r64[IN_W-1:0];
      n   = $urandom_range(0, 12);
      md  = 1'($urandom_range(0, 1));
      cv  = OUT_W'($urandom);
      es  = model_sig(sd, n, md, cv);
      if ($urandom_range(0, 1) == 1) es = es ^ (OUT_W'(1) << $urandom_range(0, OUT_W - 1));
      run_test("rand", sd, n, md, cv, es);
    end

    // Golden model run
    run_test("golden", 60'h123456789ABCDEF, 100, 1'b1, '0,
             model_sig(60'h123456789ABCDEF, 100, 1'b1, '0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bench_bist_ctrl.md
BENCH_BIST_CTRL -- requirements
Module: bench_bist_ctrl

Interface
REQ-001 Parameter IN_W, default 60, is the width of the pattern bus driven into bench_comb.
REQ-002 Parameter OUT_W, default 26, is the width of the response bus captured from bench_comb.
REQ-003 Parameter CNT_W, default 16, is the width of the pattern counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have the following ports:
- start  input  1  request to begin a test run, sampled in IDLE only.
- abort  input  1  cancels the run in progress.
- seed  input  IN_W  LFSR seed, sampled in SEED.
- num_patterns  input  CNT_W  patterns to apply (N), sampled at start.
- golden_sig  input  OUT_W  expected signature, sampled in COMPARE.
- dut_in  output  IN_W  registered pattern driven to the bench_comb in port.
- dut_out  input  OUT_W  bench_comb out port response.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- pass  output  1  sticky result: signature matched.
- fail  output  1  sticky result: signature mismatched.
- signature  output  OUT_W  current MISR contents.

Function
REQ-010 The FSM SHALL have the states IDLE, SEED, APPLY, CAPTURE, COMPARE and DONE.
REQ-011 IDLE -> SEED SHALL occur when start=1; at that edge the block latches N and clears pass and fail.
REQ-012 In SEED the block SHALL load the LFSR with seed, or with 1 if seed==0, clear the MISR, and clear the counter.
- If N==0, SEED -> COMPARE.
- Otherwise, SEED -> APPLY.
REQ-013 In APPLY, dut_in SHALL equal the LFSR value, which is held one cycle for settling; APPLY -> CAPTURE.
REQ-014 In CAPTURE the block SHALL perform the following updates:
- MISR <= {misr[OUT_W-2:0], misr[25]^misr[5]^misr[1]^misr[0]} ^ dut_out.
- LFSR <= {lfsr[IN_W-2:0], lfsr[59]^lfsr[58]}.
- counter increments.
REQ-015 CAPTURE -> COMPARE SHALL occur when the incremented counter equals N; otherwise CAPTURE -> APPLY.
REQ-016 In COMPARE the block SHALL set pass=(signature==golden_sig) and fail=!pass; COMPARE -> DONE.
REQ-017 In DONE, done=1 for exactly one cycle; DONE -> IDLE.
REQ-018 For N>=1, done SHALL assert exactly 2N+3 cycles after the edge at which start is sampled; for N==0, after 3 cycles.
REQ-019 start SHALL be ignored while busy=1; a start held continuously SHALL launch a new run on the first cycle back in IDLE.
REQ-020 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse, leave pass=fail=0, and freeze signature.
REQ-021 When start and abort are both high in IDLE, abort SHALL win and no run starts.
REQ-022 The counter SHALL not wrap: N=2^CNT_W-1 SHALL complete normally.
REQ-023 dut_in SHALL hold its last value outside APPLY/CAPTURE; signature SHALL hold outside SEED/CAPTURE.
REQ-024 pass and fail SHALL never both be 1.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL take the following values regardless of state:
- state=IDLE.
- busy=0, done=0, pass=0, fail=0.
- dut_in=0, signature=0.
- LFSR=1, counter=0.
REQ-031 Reset mid-run SHALL discard the run with no done pulse; the first start after rst deasserts SHALL behave as a fresh run.

Verification
REQ-040 Single pattern: seed=1, N=1, dut_out tied to 26'h0000001, golden_sig=26'h0000001 -> dut_in=60'h1 in APPLY, signature=26'h0000001, done 5 cycles after start, pass=1.
REQ-041 Two patterns: seed=1, N=2, dut_out tied to 26'h0000001, golden_sig=26'h0000003 -> dut_in sequence 60'h1 then 60'h2, signature=26'h0000002, fail=1, done 7 cycles after start.
REQ-042 Zero-pattern run: N=0, golden_sig=0 -> no APPLY state, signature=0, pass=1, done 3 cycles after start.
REQ-043 Abort mid-run: N=10, abort pulsed in the 4th APPLY -> IDLE next cycle, busy=0, no done, pass=fail=0; a following start with N=1 completes normally.
REQ-044 Reset mid-run: rst pulsed during CAPTURE -> all outputs at reset values next cycle; start blocked while busy, then a restart gives the same signature as an uninterrupted run.
REQ-045 Golden model: dut_out driven from a reference bench_comb (out[0]=in0&in1, out[1]=in0|in1, out[i]=~in[i] for i>=2), seed=60'h123456789ABCDEF, N=100 -> signature equals the software MISR model and pass=1.
